input_conditioner: RTL and testbench
====================================

// Module: input_conditioner
// PURPOSE
//  Upstream front end for the mux/priority-encoder/rotate stage. Synchronises
//  and debounces raw switch vector raw_w and step button btn_step. Drives the
//  clean w vector, per-bit rising-edge pulses and the 2-bit sel counter.
//  sel advances by one on each debounced btn_step press.
// PARAMETERS
//  W            4   width of raw_w / w_clean / w_rise
//  SYNC_STAGES  2   synchroniser flops per input bit (>=2)
//  DBNC_CYCLES  16  stable cycles required before w_clean follows (>=2)
// PORTS
//  clk       in   1  clock, all flops on posedge
//  rst       in   1  asynchronous reset, active-high
//  raw_w     in   W  asynchronous switch inputs
//  btn_step  in   1  asynchronous step button, active-high
//  w_clean   out  W  conditioned level of raw_w, to encoder/mux w
//  w_rise    out  W  1-cycle pulse per bit on w_clean 0->1
//  sel       out  2  mux select counter
//  sel_wrap  out  1  1-cycle pulse when sel wraps 3->0
//  w_valid   out  1  high once startup settling is complete
// BEHAVIOUR
//  - Reset (async, dominates all events): every flop clears. w_clean=0,
//    w_rise=0, sel=0, sel_wrap=0, w_valid=0, sync/debounce/startup counters=0.
//    Reset mid-debounce discards partial counts. No output glitches after
//    deassertion.
//  - Sync: each raw_w bit and btn_step go through SYNC_STAGES flops.
//    btn_step is handled as internal bit W, with an identical path.
//  - Debounce, per bit: cnt=0 while sync_out==clean. While they differ,
//    cnt increments each cycle. If sync_out differs with cnt==DBNC_CYCLES-1,
//    then on the next edge clean<=sync_out and cnt<=0.
//    Any return to equality before that clears cnt (glitch rejected).
//  - Latency raw->w_clean: SYNC_STAGES+DBNC_CYCLES edges for a stable change.
//    Pulses shorter than DBNC_CYCLES cycles after sync never reach w_clean.
//  - Edge detect: registered copy clean_q. rise = clean & ~clean_q.
//    w_rise is rise gated by w_valid, combinational, high exactly one cycle.
//    No pulse on falling edges.
//  - Startup: counter runs from reset deassertion.
//    w_valid rises after SYNC_STAGES+DBNC_CYCLES edges, then stays high
//    until the next rst. Before w_valid: w_rise forced 0, steps ignored.
//  - sel: on an edge where step_rise=1 and w_valid=1, sel<=sel+1 (mod 4).
//    - Transition 3->0: sel_wrap registered high for that one cycle.
//    - Otherwise sel_wrap is 0.
//    - Holding btn_step gives a single step; re-press requires release
//      through debounce.
//  - Simultaneous changes: bits debounce independently. Bit and step edges
//    in the same cycle are all honoured.
//  - FSM per debounce lane: STABLE (cnt=0) -> COUNTING on mismatch.
//    COUNTING -> STABLE on match or on commit at terminal count.
// CONFIGURATION
//  Macro INPUT_CONDITIONER_DEBOUNCE_EN:
//  - Defined: debounce counters as above, cnt width $clog2(DBNC_CYCLES).
//  - Undefined: no counters. Each cycle clean<=sync_out.
//    - Latency raw->w_clean: SYNC_STAGES+1 edges.
//    - w_valid rises after SYNC_STAGES+1 edges.
//    - DBNC_CYCLES ignored. Edge detect, sel and sel_wrap unchanged.
// TESTING (SYNC_STAGES=2, DBNC_CYCLES=4, macro defined unless noted)
//  1 Reset: rst=1 with random inputs -> all outputs 0. Release ->
//    w_valid=1 on 6th edge.
//  2 raw_w 0000->0101 held -> w_clean=0101 on 6th edge. w_rise=0101 for
//    1 cycle, then 0000.
//  3 Glitch: raw_w[2] high for 3 cycles -> w_clean[2] stays 0, w_rise[2]
//    never pulses.
//  4 Four clean btn_step presses (8 cycles each) -> sel 1,2,3,0.
//    sel_wrap=1 only on 4th step. A held button gives one step.
//  5 rst asserted mid-count with sel=2 -> sel=0 immediately, w_clean=0.
//    A post-reset step is ignored until w_valid.
//  6 Macro undefined: raw_w 0000->1000 -> w_clean=1000 on 3rd edge.
//    3-cycle glitch propagates.

Source files
------------

// File: rtl/input_conditioner_if.sv
// Switch/button front-end bundle between the board inputs and the mux/encoder stage.
// master drives the raw inputs; slave (the conditioner) drives the cleaned outputs.
interface input_conditioner_if #(
    parameter int W = 4
);
    logic [W-1:0] raw_w;
    logic         btn_step;
    logic [W-1:0] w_clean;
    logic [W-1:0] w_rise;
    logic [1:0]   sel;
    logic         sel_wrap;
    logic         w_valid;

    modport master (
        output raw_w, btn_step,
        input  w_clean, w_rise, sel, sel_wrap, w_valid
    );

    modport slave (
        input  raw_w, btn_step,
        output w_clean, w_rise, sel, sel_wrap, w_valid
    );
endinterface

// File: rtl/input_conditioner.sv
// Synchronise, debounce and edge-detect switch inputs plus a step button driving sel.
// Debounce counters exist only when INPUT_CONDITIONER_DEBOUNCE_EN is defined.
//
// Debounce lane states:
//   state        | meaning
//   ST_STABLE    | sync output equals clean level, cnt = 0
//   ST_COUNTING  | sync output differs, cnt counts stable cycles toward commit
module input_conditioner #(
    parameter int W           = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DBNC_CYCLES = 16
) (
    input logic                clk,
    input logic                rst,
    input_conditioner_if.slave bus
);

    // Lane W carries btn_step through the same path as the switch bits.
    localparam int L = W + 1;
`ifdef INPUT_CONDITIONER_DEBOUNCE_EN
    localparam int STARTUP = SYNC_STAGES + DBNC_CYCLES;
`else
    localparam int STARTUP = SYNC_STAGES + 1;
`endif
    localparam int SCW = $clog2(SYNC_STAGES + DBNC_CYCLES + 1);

    logic [L-1:0]   sync_q [SYNC_STAGES];
    logic [L-1:0]   sync_out;
    logic [L-1:0]   clean;
    logic [L-1:0]   clean_q;
    logic [L-1:0]   rise;
    logic [SCW-1:0] start_cnt;
    logic           valid_q;
    logic [1:0]     sel_q;
    logic           sel_wrap_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= {bus.btn_step, bus.raw_w};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef INPUT_CONDITIONER_DEBOUNCE_EN
    localparam int CW = $clog2(DBNC_CYCLES);

    typedef enum logic {
        ST_STABLE,
        ST_COUNTING
    } lane_state_t;

    for (genvar g = 0; g < L; g++) begin : g_lane
        lane_state_t   state;
        logic [CW-1:0] cnt;
        logic          lane_clean;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state      <= ST_STABLE;
                cnt        <= '0;
                lane_clean <= 1'b0;
            end else begin
                case (state)
                    ST_STABLE: begin
                        if (sync_out[g] != lane_clean) begin
                            state <= ST_COUNTING;
                            cnt   <= cnt + 1'b1;
                        end
                    end
                    ST_COUNTING: begin
                        if (sync_out[g] == lane_clean) begin
                            state <= ST_STABLE;
                            cnt   <= '0;
                        end else if (cnt == CW'(DBNC_CYCLES - 1)) begin
                            state      <= ST_STABLE;
                            cnt        <= '0;
                            lane_clean <= sync_out[g];
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= ST_STABLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end

        assign clean[g] = lane_clean;
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) clean <= '0;
        else     clean <= sync_out;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) clean_q <= '0;
        else     clean_q <= clean;
    end

    assign rise = clean & ~clean_q;

    // Startup counter freezes once valid so it never wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_cnt <= '0;
            valid_q   <= 1'b0;
        end else if (!valid_q) begin
            start_cnt <= start_cnt + 1'b1;
            if (start_cnt == SCW'(STARTUP - 1)) valid_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q      <= 2'd0;
            sel_wrap_q <= 1'b0;
        end else if (rise[W] && valid_q) begin
            sel_q      <= sel_q + 2'd1;
            sel_wrap_q <= (sel_q == 2'd3);
        end else begin
            sel_wrap_q <= 1'b0;
        end
    end

    assign bus.w_clean  = clean[W-1:0];
    assign bus.w_rise   = rise[W-1:0] & {W{valid_q}};
    assign bus.sel      = sel_q;
    assign bus.sel_wrap = sel_wrap_q;
    assign bus.w_valid  = valid_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with SYNC_STAGES=2, DBNC_CYCLES=4.
// Expected latencies follow INPUT_CONDITIONER_DEBOUNCE_EN, so one bench serves both builds.
module tb_input_conditioner;

    localparam int W = 4;
`ifdef INPUT_CONDITIONER_DEBOUNCE_EN
    localparam int LAT     = 6;
    localparam bit DBNC_ON = 1'b1;
`else
    localparam int LAT     = 3;
    localparam bit DBNC_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   sel_exp = 0;

    input_conditioner_if #(.W(W)) bus ();

    input_conditioner #(
        .W(W),
        .SYNC_STAGES(2),
        .DBNC_CYCLES(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.raw_w    = 4'($urandom);
        bus.btn_step = 1'($urandom);
        repeat (3) tick();
        total++; if (bus.w_clean !== 4'b0) begin bad++; $display("FAIL reset_w_clean: got %b expected 0000", bus.w_clean); end
        total++; if (bus.w_rise !== 4'b0) begin bad++; $display("FAIL reset_w_rise: got %b expected 0000", bus.w_rise); end
        total++; if (bus.sel !== 2'd0) begin bad++; $display("FAIL reset_sel: got %0d expected 0", bus.sel); end
        total++; if (bus.sel_wrap !== 1'b0) begin bad++; $display("FAIL reset_sel_wrap: got %b expected 0", bus.sel_wrap); end
        total++; if (bus.w_valid !== 1'b0) begin bad++; $display("FAIL reset_w_valid: got %b expected 0", bus.w_valid); end
        bus.raw_w    = 4'b0;
        bus.btn_step = 1'b0;
        rst = 1'b0;
        for (int k = 1; k <= LAT + 1; k++) begin
            logic exp_v;
            tick();
            exp_v = (k >= LAT);
            total++;
            if (bus.w_valid !== exp_v) begin
                bad++; $display("FAIL startup_w_valid edge %0d: got %b expected %b", k, bus.w_valid, exp_v);
            end
        end
    endtask

    task automatic test_rise_fall();
        bus.raw_w = 4'b0101;
        for (int k = 1; k <= LAT + 1; k++) begin
            logic [3:0] exp_c, exp_r;
            tick();
            exp_c = (k >= LAT) ? 4'b0101 : 4'b0000;
            exp_r = (k == LAT) ? 4'b0101 : 4'b0000;
            total++; if (bus.w_clean !== exp_c) begin bad++; $display("FAIL rise_w_clean edge %0d: got %b expected %b", k, bus.w_clean, exp_c); end
            total++; if (bus.w_rise !== exp_r) begin bad++; $display("FAIL rise_w_rise edge %0d: got %b expected %b", k, bus.w_rise, exp_r); end
        end
        bus.raw_w = 4'b0000;
        for (int k = 1; k <= LAT + 1; k++) begin
            logic [3:0] exp_c;
            tick();
            exp_c = (k >= LAT) ? 4'b0000 : 4'b0101;
            total++; if (bus.w_clean !== exp_c) begin bad++; $display("FAIL fall_w_clean edge %0d: got %b expected %b", k, bus.w_clean, exp_c); end
            total++; if (bus.w_rise !== 4'b0) begin bad++; $display("FAIL fall_w_rise edge %0d: got %b expected 0000", k, bus.w_rise); end
        end
    endtask

    task automatic test_glitch();
        bus.raw_w = 4'b0100;
        for (int k = 1; k <= 12; k++) begin
            logic [3:0] exp_c, exp_r;
            tick();
            exp_c = (!DBNC_ON && k >= 3 && k <= 5) ? 4'b0100 : 4'b0000;
            exp_r = (!DBNC_ON && k == 3) ? 4'b0100 : 4'b0000;
            total++; if (bus.w_clean !== exp_c) begin bad++; $display("FAIL glitch_w_clean edge %0d: got %b expected %b", k, bus.w_clean, exp_c); end
            total++; if (bus.w_rise !== exp_r) begin bad++; $display("FAIL glitch_w_rise edge %0d: got %b expected %b", k, bus.w_rise, exp_r); end
            if (k == 3) bus.raw_w = 4'b0000;
        end
    endtask

    task automatic test_steps();
        for (int p = 0; p < 4; p++) begin
            bus.btn_step = 1'b1;
            for (int k = 1; k <= 16; k++) begin
                logic [1:0] exp_s;
                logic       exp_w;
                tick();
                exp_s = (k >= LAT + 1) ? 2'(sel_exp + 1) : 2'(sel_exp);
                exp_w = (k == LAT + 1) && (sel_exp == 3);
                total++; if (bus.sel !== exp_s) begin bad++; $display("FAIL step%0d_sel edge %0d: got %0d expected %0d", p, k, bus.sel, exp_s); end
                total++; if (bus.sel_wrap !== exp_w) begin bad++; $display("FAIL step%0d_sel_wrap edge %0d: got %b expected %b", p, k, bus.sel_wrap, exp_w); end
                if (k == 8) bus.btn_step = 1'b0;
            end
            sel_exp = (sel_exp + 1) % 4;
        end
    endtask

    task automatic test_held_button();
        bus.btn_step = 1'b1;
        for (int k = 1; k <= 56; k++) begin
            logic [1:0] exp_s;
            logic       exp_w;
            tick();
            exp_s = (k >= LAT + 1) ? 2'(sel_exp + 1) : 2'(sel_exp);
            exp_w = (k == LAT + 1) && (sel_exp == 3);
            total++; if (bus.sel !== exp_s) begin bad++; $display("FAIL held_sel edge %0d: got %0d expected %0d", k, bus.sel, exp_s); end
            total++; if (bus.sel_wrap !== exp_w) begin bad++; $display("FAIL held_sel_wrap edge %0d: got %b expected %b", k, bus.sel_wrap, exp_w); end
            if (k == 40) bus.btn_step = 1'b0;
        end
        sel_exp = (sel_exp + 1) % 4;
    endtask

    task automatic test_reset_mid_count();
        bus.btn_step = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (k == 8) bus.btn_step = 1'b0;
        end
        sel_exp = (sel_exp + 1) % 4;
        total++; if (bus.sel !== 2'(sel_exp)) begin bad++; $display("FAIL pre_reset_sel: got %0d expected %0d", bus.sel, sel_exp); end
        bus.raw_w = 4'b0011;
        repeat (LAT + 2) tick();
        total++; if (bus.w_clean !== 4'b0011) begin bad++; $display("FAIL pre_reset_w_clean: got %b expected 0011", bus.w_clean); end
        bus.btn_step = 1'b1;
        repeat (3) tick();
        #2 rst = 1'b1;
        #1;
        total++; if (bus.sel !== 2'd0) begin bad++; $display("FAIL async_reset_sel: got %0d expected 0", bus.sel); end
        total++; if (bus.w_clean !== 4'b0) begin bad++; $display("FAIL async_reset_w_clean: got %b expected 0000", bus.w_clean); end
        total++; if (bus.w_valid !== 1'b0) begin bad++; $display("FAIL async_reset_w_valid: got %b expected 0", bus.w_valid); end
        total++; if (bus.sel_wrap !== 1'b0) begin bad++; $display("FAIL async_reset_sel_wrap: got %b expected 0", bus.sel_wrap); end
        tick();
        rst = 1'b0;
        sel_exp = 0;
        for (int k = 1; k <= LAT; k++) begin
            logic exp_v;
            tick();
            exp_v = (k >= LAT);
            total++; if (bus.sel !== 2'd0) begin bad++; $display("FAIL post_reset_sel edge %0d: got %0d expected 0", k, bus.sel); end
            total++; if (bus.w_valid !== exp_v) begin bad++; $display("FAIL post_reset_w_valid edge %0d: got %b expected %b", k, bus.w_valid, exp_v); end
            if (k < LAT) begin
                total++; if (bus.w_rise !== 4'b0) begin bad++; $display("FAIL post_reset_w_rise edge %0d: got %b expected 0000", k, bus.w_rise); end
            end
        end
        bus.btn_step = 1'b0;
        bus.raw_w    = 4'b0;
        rst = 1'b1;
        tick();
    endtask

    initial begin
        bus.raw_w    = 4'b0;
        bus.btn_step = 1'b0;
        test_reset();
        test_rise_fall();
        test_glitch();
        test_steps();
        test_held_button();
        test_reset_mid_count();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
